// File: rtl/data_types.sv
// rtl/data_types.sv - shared datapath word, reservation-station tag and CDB term types
package data_types;

  typedef logic [31:0] word32_t;
  typedef logic [4:0]  rs_tag_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  // Tag value meaning "no producer on this CDB term"
  localparam rs_tag_t NO_VAL = 5'h1F;

endpackage

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - one-at-a-time sequencer from load/store buffer head to data memory
// Loads broadcast their result on the CDB for one cycle; stores complete silently.
module lsu_mem_port
  import data_types::*;
(
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    lsu_empty_i,
  input  word32_t lsu_eff_addr_i,
  input  word32_t lsu_st_data_i,
  input  rs_tag_t lsu_ld_tag_i,
  input  logic    lsu_load_i,
  input  logic    lsu_instr_ready_i,
  output logic    lsu_read_o,
  output cdb_t    cdb_load_o,
  input  word32_t dmem_rd_data_i,
  input  logic    dmem_done_i,
  output logic    dmem_read_o,
  output logic    dmem_write_o,
  output word32_t dmem_addr_o,
  output word32_t dmem_data_o
);

  typedef enum logic [1:0] {IDLE, LD_REQ, ST_REQ, LD_BCAST} state_e;

  state_e  state_q, state_d;
  word32_t addr_q;
  word32_t st_data_q;
  rs_tag_t tag_q;
  logic    load_q;
  word32_t rd_data_q;
  logic    accept;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      st_data_q <= '0;
      tag_q     <= '0;
      load_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= lsu_eff_addr_i;
        st_data_q <= lsu_st_data_i;
        tag_q     <= lsu_ld_tag_i;
        load_q    <= lsu_load_i;
      end
      if (state_q == LD_REQ && dmem_done_i) begin
        rd_data_q <= dmem_rd_data_i;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    lsu_read_o     = 1'b0;
    dmem_read_o    = 1'b0;
    dmem_write_o   = 1'b0;
    cdb_load_o.tag = NO_VAL;
    cdb_load_o.val = '0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so a pop is never issued for an entry that would not be captured
        accept     = !lsu_empty_i && lsu_instr_ready_i && !reset_i;
        lsu_read_o = accept;
        if (accept) begin
          state_d = lsu_load_i ? LD_REQ : ST_REQ;
        end
      end
      LD_REQ: begin
        dmem_read_o = 1'b1;
        if (dmem_done_i) state_d = LD_BCAST;
      end
      ST_REQ: begin
        dmem_write_o = 1'b1;
        if (dmem_done_i) state_d = IDLE;
      end
      LD_BCAST: begin
        if (load_q) begin
          cdb_load_o.tag = tag_q;
          cdb_load_o.val = rd_data_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_addr_o = addr_q;
  assign dmem_data_o = st_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed self-checking bench for lsu_mem_port
module tb_lsu_mem_port;
  import data_types::*;

  logic    clk_i = 1'b0;
  logic    reset_i;
  logic    lsu_empty_i;
  word32_t lsu_eff_addr_i;
  word32_t lsu_st_data_i;
  rs_tag_t lsu_ld_tag_i;
  logic    lsu_load_i;
  logic    lsu_instr_ready_i;
  logic    lsu_read_o;
  cdb_t    cdb_load_o;
  word32_t dmem_rd_data_i;
  logic    dmem_done_i;
  logic    dmem_read_o;
  logic    dmem_write_o;
  word32_t dmem_addr_o;
  word32_t dmem_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_port dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .lsu_empty_i       (lsu_empty_i),
    .lsu_eff_addr_i    (lsu_eff_addr_i),
    .lsu_st_data_i     (lsu_st_data_i),
    .lsu_ld_tag_i      (lsu_ld_tag_i),
    .lsu_load_i        (lsu_load_i),
    .lsu_instr_ready_i (lsu_instr_ready_i),
    .lsu_read_o        (lsu_read_o),
    .cdb_load_o        (cdb_load_o),
    .dmem_rd_data_i    (dmem_rd_data_i),
    .dmem_done_i       (dmem_done_i),
    .dmem_read_o       (dmem_read_o),
    .dmem_write_o      (dmem_write_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_data_o       (dmem_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven, outputs checked after #1
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic head(input logic empty, input logic ready, input logic load,
                      input word32_t addr, input word32_t data, input rs_tag_t tag);
    lsu_empty_i       = empty;
    lsu_instr_ready_i = ready;
    lsu_load_i        = load;
    lsu_eff_addr_i    = addr;
    lsu_st_data_i     = data;
    lsu_ld_tag_i      = tag;
  endtask

  task automatic check_idle_cdb(input string tag);
    check_eq({tag, "_cdb_tag"}, 64'(cdb_load_o.tag), 64'(NO_VAL));
    check_eq({tag, "_cdb_val"}, 64'(cdb_load_o.val), 64'h0);
  endtask

  initial begin
    reset_i        = 1'b1;
    dmem_done_i    = 1'b0;
    dmem_rd_data_i = '0;
    head(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check_eq("rst_pop",   64'(lsu_read_o),   64'h0);
    check_eq("rst_rd",    64'(dmem_read_o),  64'h0);
    check_eq("rst_wr",    64'(dmem_write_o), 64'h0);
    check_eq("rst_addr",  64'(dmem_addr_o),  64'h0);
    check_eq("rst_data",  64'(dmem_data_o),  64'h0);
    check_idle_cdb("rst");

    // Empty but ready: never popped
    head(1'b1, 1'b1, 1'b1, 32'h123, 32'h0, 5'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check_eq("empty_pop", 64'(lsu_read_o),   64'h0);
      check_eq("empty_rd",  64'(dmem_read_o),  64'h0);
      check_eq("empty_wr",  64'(dmem_write_o), 64'h0);
      check_eq("empty_cdb", 64'(cdb_load_o.tag), 64'(NO_VAL));
    end

    // Load 0x100 tag 5, done in third request cycle
    tick();
    head(1'b0, 1'b1, 1'b1, 32'h100, 32'hAAAA_0000, 5'd5);
    #1;
    check_eq("ld_pop", 64'(lsu_read_o), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      head(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      if (i == 2) begin
        dmem_done_i    = 1'b1;
        dmem_rd_data_i = 32'hDEAD_BEEF;
      end
      #1;
      check_eq("ld_nopop", 64'(lsu_read_o),  64'h0);
      check_eq("ld_rd",    64'(dmem_read_o), 64'h1);
      check_eq("ld_addr",  64'(dmem_addr_o), 64'h100);
      check_idle_cdb("ld_wait");
    end
    tick();
    dmem_done_i    = 1'b0;
    dmem_rd_data_i = '0;
    #1;
    check_eq("ld_rd_drop", 64'(dmem_read_o),    64'h0);
    check_eq("ld_bc_tag",  64'(cdb_load_o.tag), 64'h5);
    check_eq("ld_bc_val",  64'(cdb_load_o.val), 64'hDEAD_BEEF);
    tick();
    #1;
    check_idle_cdb("ld_after");

    // Two back-to-back stores, zero-wait done held high throughout
    tick();
    head(1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, 5'd1);
    #1;
    check_eq("st1_pop", 64'(lsu_read_o),   64'h1);
    check_eq("st1_wr0", 64'(dmem_write_o), 64'h0);
    tick();
    head(1'b0, 1'b1, 1'b0, 32'h44, 32'h9ABC_DEF0, 5'd1);
    dmem_done_i = 1'b1;
    #1;
    check_eq("st1_nopop", 64'(lsu_read_o),   64'h0);
    check_eq("st1_wr",    64'(dmem_write_o), 64'h1);
    check_eq("st1_addr",  64'(dmem_addr_o),  64'h40);
    check_eq("st1_data",  64'(dmem_data_o),  64'h1234_5678);
    check_idle_cdb("st1");
    tick();
    #1;
    check_eq("st2_pop", 64'(lsu_read_o),   64'h1);
    check_eq("st2_wr0", 64'(dmem_write_o), 64'h0);
    check_idle_cdb("st2_idle");
    tick();
    head(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check_eq("st2_wr",   64'(dmem_write_o), 64'h1);
    check_eq("st2_addr", 64'(dmem_addr_o),  64'h44);
    check_eq("st2_data", 64'(dmem_data_o),  64'h9ABC_DEF0);
    tick();
    dmem_done_i = 1'b0;
    #1;
    check_eq("st_end_wr",  64'(dmem_write_o), 64'h0);
    check_eq("st_end_pop", 64'(lsu_read_o),   64'h0);
    check_idle_cdb("st_end");

    // Head address changes after acceptance; transaction keeps 0x200
    tick();
    head(1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd7);
    #1;
    check_eq("hold_pop", 64'(lsu_read_o), 64'h1);
    tick();
    head(1'b0, 1'b0, 1'b1, 32'h999, 32'h0, 5'd8);
    #1;
    check_eq("hold_addr1", 64'(dmem_addr_o), 64'h200);
    tick();
    dmem_done_i    = 1'b1;
    dmem_rd_data_i = 32'h55;
    #1;
    check_eq("hold_addr2", 64'(dmem_addr_o), 64'h200);
    check_eq("hold_rd",    64'(dmem_read_o), 64'h1);
    tick();
    dmem_done_i    = 1'b0;
    dmem_rd_data_i = '0;
    head(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check_eq("hold_bc_tag", 64'(cdb_load_o.tag), 64'h7);
    check_eq("hold_bc_val", 64'(cdb_load_o.val), 64'h55);
    check_eq("hold_addr3",  64'(dmem_addr_o),    64'h200);

    // Reset during LD_REQ concurrent with done
    tick();
    head(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd9);
    #1;
    check_eq("rld_pop", 64'(lsu_read_o), 64'h1);
    tick();
    head(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    reset_i        = 1'b1;
    dmem_done_i    = 1'b1;
    dmem_rd_data_i = 32'h77;
    #1;
    check_eq("rld_rd_pre", 64'(dmem_read_o), 64'h1);
    tick();
    reset_i        = 1'b0;
    dmem_done_i    = 1'b0;
    dmem_rd_data_i = '0;
    #1;
    check_eq("rld_rd",   64'(dmem_read_o), 64'h0);
    check_eq("rld_addr", 64'(dmem_addr_o), 64'h0);
    check_idle_cdb("rld0");
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check_idle_cdb("rld_later");
      check_eq("rld_rd_later", 64'(dmem_read_o), 64'h0);
    end

    // Load tag 3 then store: read, broadcast, idle+pop, write
    tick();
    head(1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd3);
    #1;
    check_eq("ord_pop1", 64'(lsu_read_o), 64'h1);
    tick();
    head(1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_CAFE, 5'd4);
    dmem_done_i    = 1'b1;
    dmem_rd_data_i = 32'h1111;
    #1;
    check_eq("ord_rd",    64'(dmem_read_o), 64'h1);
    check_eq("ord_nopop", 64'(lsu_read_o),  64'h0);
    tick();
    dmem_done_i    = 1'b0;
    dmem_rd_data_i = '0;
    #1;
    check_eq("ord_bc_tag", 64'(cdb_load_o.tag), 64'h3);
    check_eq("ord_bc_val", 64'(cdb_load_o.val), 64'h1111);
    check_eq("ord_bc_pop", 64'(lsu_read_o),     64'h0);
    check_eq("ord_bc_rd",  64'(dmem_read_o),    64'h0);
    tick();
    #1;
    check_eq("ord_pop2", 64'(lsu_read_o),   64'h1);
    check_eq("ord_wr0",  64'(dmem_write_o), 64'h0);
    check_idle_cdb("ord_idle");
    tick();
    head(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_done_i = 1'b1;
    #1;
    check_eq("ord_wr",   64'(dmem_write_o), 64'h1);
    check_eq("ord_addr", 64'(dmem_addr_o),  64'h20);
    check_eq("ord_data", 64'(dmem_data_o),  64'h0000_CAFE);
    check_idle_cdb("ord_wr");
    tick();
    dmem_done_i = 1'b0;
    #1;
    check_eq("ord_end_wr", 64'(dmem_write_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
